// File: rtl/block_mean_accum.sv
// Block pixel-mean accumulator: sums a block of pixels, presents sum/count to an external divider and captures the mean. MEAN_ROUND_EN selects round-half-up over truncation.
// Latency DIV_WAIT+1 cycles from end_of_block to mean_valid; no backpressure, block inputs are ignored while the divide is in flight.
module block_mean_accum #(
  parameter int PIX_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int DIV_WAIT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_of_block,
  input  logic                 pixel_valid,
  input  logic [PIX_WIDTH-1:0] pixel_in,
  input  logic                 end_of_block,
  output logic [ACC_WIDTH-1:0] div_a,
  output logic [ACC_WIDTH-1:0] div_b,
  input  logic [ACC_WIDTH-1:0] div_quotient,
  input  logic [ACC_WIDTH-1:0] div_remainder,
  input  logic                 div_by_0,
  output logic [ACC_WIDTH-1:0] mean_out,
  output logic                 mean_valid,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(DIV_WAIT - 1);

  state_t               state_q;
  logic [ACC_WIDTH-1:0] sum_q, cnt_q, mean_q;
  logic                 err_q, mean_vld_q, busy_q;
  logic [3:0]           wait_q;

  logic [ACC_WIDTH-1:0] sum_base, cnt_base, sum_d, cnt_d, mean_d;
  logic [ACC_WIDTH:0]   pix_ext, sum_ext;
  logic                 sum_sat, err_d;

  // A start clears the running totals before the coincident pixel is folded in.
  always_comb begin
    sum_base = start_of_block ? '0 : sum_q;
    cnt_base = start_of_block ? '0 : cnt_q;
    pix_ext  = {{(ACC_WIDTH + 1 - PIX_WIDTH){1'b0}}, pixel_in};
    sum_ext  = {1'b0, sum_base} + pix_ext;
    sum_sat  = 1'b0;
    sum_d    = sum_base;
    cnt_d    = cnt_base;
    if (pixel_valid) begin
      if (sum_ext[ACC_WIDTH]) begin
        sum_d   = '1;
        sum_sat = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_WIDTH-1:0];
      end
      cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + ACC_WIDTH'(1);
    end
    err_d = (start_of_block ? 1'b0 : err_q) | sum_sat;
  end

`ifdef MEAN_ROUND_EN
  logic round_up;
  assign round_up = ({div_remainder, 1'b0} >= {1'b0, cnt_q});
  assign mean_d   = div_by_0 ? '0 : div_quotient + {{(ACC_WIDTH-1){1'b0}}, round_up};
`else
  logic unused_rem;
  assign unused_rem = ^div_remainder;
  assign mean_d     = div_by_0 ? '0 : div_quotient;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      mean_q     <= '0;
      err_q      <= 1'b0;
      mean_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      wait_q     <= '0;
    end else begin
      mean_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_of_block) begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q <= sum_d;
          cnt_q <= cnt_d;
          err_q <= err_d;
          // A coincident start restarts the block and keeps accumulating.
          if (end_of_block && !start_of_block) begin
            wait_q  <= WAIT_INIT;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (wait_q == '0) begin
            mean_q     <= mean_d;
            mean_vld_q <= 1'b1;
            if (div_by_0) err_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_a      = sum_q;
  assign div_b      = cnt_q;
  assign mean_out   = mean_q;
  assign mean_valid = mean_vld_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_block_mean_accum.sv
// Scoreboard bench for block_mean_accum: a combinational divider model feeds the DUT; a 16-bit accumulator copy exercises saturation.
module tb_block_mean_accum;
  localparam int PW  = 8;
  localparam int AW  = 32;
  localparam int DW  = 1;
  localparam int SAW = 16;

  logic          clk = 1'b0;
  logic          rst_n, sob, pv, eob;
  logic [PW-1:0] pix;

  logic [AW-1:0] div_a, div_b, dq, dr, mean_out;
  logic          dz, mean_valid, busy, err;

  logic [SAW-1:0] sat_a, sat_b, sat_q, sat_r, sat_mean;
  logic           sat_dz, sat_mv, sat_busy, sat_err;

  assign dz     = (div_b == '0);
  assign dq     = dz ? '0 : div_a / div_b;
  assign dr     = dz ? '0 : div_a % div_b;
  assign sat_dz = (sat_b == '0);
  assign sat_q  = sat_dz ? '0 : sat_a / sat_b;
  assign sat_r  = sat_dz ? '0 : sat_a % sat_b;

  block_mean_accum #(.PIX_WIDTH(PW), .ACC_WIDTH(AW), .DIV_WAIT(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_of_block(sob), .pixel_valid(pv), .pixel_in(pix),
    .end_of_block(eob), .div_a(div_a), .div_b(div_b), .div_quotient(dq),
    .div_remainder(dr), .div_by_0(dz), .mean_out(mean_out), .mean_valid(mean_valid),
    .busy(busy), .err(err)
  );

  block_mean_accum #(.PIX_WIDTH(PW), .ACC_WIDTH(SAW), .DIV_WAIT(DW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_of_block(sob), .pixel_valid(pv), .pixel_in(pix),
    .end_of_block(eob), .div_a(sat_a), .div_b(sat_b), .div_quotient(sat_q),
    .div_remainder(sat_r), .div_by_0(sat_dz), .mean_out(sat_mean), .mean_valid(sat_mv),
    .busy(sat_busy), .err(sat_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] mean;
    logic          err;
    int unsigned   due;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int pushed = 0;
  int mv_cnt = 0;
  int sat_mv_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_mean(input logic [AW-1:0] s, input logic [AW-1:0] c);
    logic [AW-1:0] q;
    logic [AW-1:0] r;
    if (c == '0) return '0;
    q = s / c;
    r = s % c;
`ifdef MEAN_ROUND_EN
    if (64'(r) * 2 >= 64'(c)) q = q + 1;
`endif
    return q;
  endfunction

  task automatic step(input logic s, input logic v, input logic [PW-1:0] p, input logic e);
    @(posedge clk);
    #1;
    sob = s; pv = v; pix = p; eob = e;
  endtask

  // Call right after the step that drives end_of_block.
  task automatic push_exp(input logic [AW-1:0] m, input logic e);
    exp_t x;
    x.mean = m;
    x.err  = e;
    x.due  = cyc + DW + 1;
    sb.push_back(x);
    pushed++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mean_valid) begin
      mv_cnt++;
      if (sb.size() == 0) begin
        check_eq("spurious_mean_valid", {63'd0, mean_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("mean_out", {32'd0, mean_out}, {32'd0, e.mean});
        check_eq("err_at_valid", {63'd0, err}, {63'd0, e.err});
        check_eq("latency", 64'(cyc), 64'(e.due));
      end
    end
    if (sat_mv) sat_mv_cnt++;
  end

  initial begin
    rst_n = 1'b0; sob = 1'b0; pv = 1'b0; eob = 1'b0; pix = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_div_a", 64'(div_a), 64'd0);
    check_eq("rst_div_b", 64'(div_b), 64'd0);
    check_eq("rst_mean", 64'(mean_out), 64'd0);
    check_eq("rst_valid", 64'(mean_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic block
    step(1, 0, 0, 0);
    step(0, 1, 10, 0); step(0, 1, 20, 0); step(0, 1, 30, 0); step(0, 1, 41, 0);
    step(0, 0, 0, 1); push_exp(exp_mean(101, 4), 1'b0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t1_div_a", 64'(div_a), 64'd101);
    check_eq("t1_div_b", 64'(div_b), 64'd4);
    check_eq("t1_busy", 64'(busy), 64'd1);
    idle(4);
    @(negedge clk);
    check_eq("t1_busy_after", 64'(busy), 64'd0);
    check_eq("t1_mean_hold", 64'(mean_out), 64'(exp_mean(101, 4)));

    // empty block
    step(1, 0, 0, 0);
    step(0, 0, 0, 1); push_exp('0, 1'b1);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t2_div_b", 64'(div_b), 64'd0);
    idle(4);
    @(negedge clk);
    check_eq("t2_err_sticky", 64'(err), 64'd1);

    // restart mid-block, end with a pixel
    step(1, 0, 0, 0);
    step(0, 1, 5, 0); step(0, 1, 7, 0);
    step(1, 1, 100, 0);
    step(0, 1, 200, 1); push_exp(exp_mean(300, 2), 1'b0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t3_div_a", 64'(div_a), 64'd300);
    check_eq("t3_div_b", 64'(div_b), 64'd2);
    check_eq("t3_err_cleared", 64'(err), 64'd0);
    idle(4);

    // start and end together: start wins
    step(1, 0, 0, 0);
    step(0, 1, 9, 0);
    step(1, 1, 4, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t3b_busy", 64'(busy), 64'd1);
    check_eq("t3b_div_a", 64'(div_a), 64'd4);
    step(0, 0, 0, 1); push_exp(exp_mean(4, 1), 1'b0);
    idle(5);

    // inputs during DIVIDE/DONE and end/pixel in IDLE are ignored
    step(1, 1, 1, 0); step(0, 1, 2, 0);
    step(0, 1, 3, 1); push_exp(exp_mean(6, 3), 1'b0);
    step(1, 1, 99, 1); step(1, 1, 99, 1);
    step(0, 1, 99, 1); step(0, 1, 99, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t4_div_a", 64'(div_a), 64'd6);
    check_eq("t4_div_b", 64'(div_b), 64'd3);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_mean", 64'(mean_out), 64'(exp_mean(6, 3)));
    idle(3);

    // reset mid-block
    step(1, 1, 3, 0); step(0, 1, 4, 0); step(0, 1, 5, 0);
    step(0, 0, 0, 0);
    check_eq("t5_pre_rst_sum", 64'(div_a), 64'd12);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_div_a", 64'(div_a), 64'd0);
    check_eq("t5_rst_div_b", 64'(div_b), 64'd0);
    check_eq("t5_rst_mean", 64'(mean_out), 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_err", 64'(err), 64'd0);
    check_eq("t5_rst_valid", 64'(mean_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 1, 7, 0);
    step(0, 1, 8, 1); push_exp(exp_mean(15, 2), 1'b0);
    idle(5);

    // saturation on the 16-bit copy
    step(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) step(0, 1, 255, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t6_sat_a_pre", 64'(sat_a), 64'd65280);
    check_eq("t6_sat_b_pre", 64'(sat_b), 64'd256);
    check_eq("t6_sat_err_pre", 64'(sat_err), 64'd0);
    step(0, 1, 255, 0); step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t6_sat_a_full", 64'(sat_a), 64'd65535);
    check_eq("t6_sat_err_full", 64'(sat_err), 64'd0);
    step(0, 1, 255, 0); step(0, 0, 0, 0);
    @(negedge clk);
    check_eq("t6_sat_a_clip", 64'(sat_a), 64'd65535);
    check_eq("t6_sat_err", 64'(sat_err), 64'd1);
    check_eq("t6_sat_busy", 64'(sat_busy), 64'd1);
    check_eq("t6_wide_a", 64'(div_a), 64'd65790);
    check_eq("t6_wide_err", 64'(err), 64'd0);
    step(0, 0, 0, 1); push_exp(exp_mean(65790, 258), 1'b0);
    idle(5);
    @(negedge clk);
    check_eq("t6_sat_mean", 64'(sat_mean), 64'(exp_mean(65535, 258)));
    check_eq("t6_sat_err_hold", 64'(sat_err), 64'd1);

    idle(3);
    @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("mean_valid_pulses", 64'(mv_cnt), 64'(pushed));
    check_eq("sat_mean_valid_pulses", 64'(sat_mv_cnt), 64'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
